program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, the instruction-memory word-address width.
REQ-002 SHALL have parameter TIMEOUT, default 1000000, the maximum number of idle cycles allowed between bytes during a load.
REQ-003 SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rx_valid  input  1  one-cycle strobe from the UART receiver: rx_data holds a received byte.
REQ-006 SHALL have port rx_data  input  8  received byte.
REQ-007 SHALL have port start_exec  input  1  level/pulse request to start the loaded program.
REQ-008 SHALL have port cpu_halt  input  1  CPU reports that the program has finished.
REQ-009 SHALL have port imem_we  output  1  instruction-memory write enable.
REQ-010 SHALL have port imem_addr  output  ADDR_W  instruction-memory word address.
REQ-011 SHALL have port imem_wdata  output  32  instruction word.
REQ-012 SHALL have port cpu_rst  output  1  one-cycle CPU/PC reset pulse.
REQ-013 SHALL have port cpu_run  output  1  CPU execute enable.
REQ-014 SHALL have port loading  output  1  high in states HDR and LOAD.
REQ-015 SHALL have port load_done  output  1  high in state READY.
REQ-016 SHALL have port error  output  1  high in state ERROR.
REQ-017 SHALL have port word_count  output  16  latched header value N.

Function
REQ-018 SHALL implement the states IDLE, HDR, LOAD, READY, RUN, and ERROR; all outputs SHALL be registered.
REQ-019 IDLE: on rx_valid, the block SHALL latch rx_data as N[15:8] and go to HDR.
REQ-020 HDR: on rx_valid, the block SHALL latch rx_data as N[7:0]; it SHALL go to READY if N==0, to ERROR if N > 2**ADDR_W, and to LOAD otherwise.
REQ-021 LOAD SHALL assemble bytes into a 32-bit word, first byte into [31:24] (big-endian), using a 2-bit byte counter.
REQ-022 For the rx_valid carrying the 4th byte at cycle t, the block SHALL at t+1 assert imem_we for exactly one cycle, with imem_addr equal to the word index (0-based) and imem_wdata equal to the assembled word.
REQ-023 After the write of word N-1, the state SHALL be READY at t+1 (the same cycle as that imem_we); the word index SHALL not wrap.
REQ-024 The timeout counter SHALL clear on every rx_valid and on entry to HDR or LOAD; it SHALL count only in HDR and LOAD.
REQ-025 When the timeout counter reaches TIMEOUT, the state SHALL go to ERROR.
REQ-026 If rx_valid arrives in the same cycle that the timeout counter reaches TIMEOUT, the byte SHALL win and no timeout SHALL occur.
REQ-027 READY: start_exec SHALL cause cpu_rst=1 for one cycle and then cpu_run=1 in RUN, i.e. cpu_rst at t+1 and cpu_run from t+2.
REQ-028 READY: rx_valid SHALL start a new load, which latches N[15:8] and goes to HDR; the old program is overwritten.
REQ-029 RUN: cpu_halt SHALL deassert cpu_run next cycle and return to READY, so the program can be re-run.
REQ-030 RUN: rx_valid and start_exec SHALL be ignored.
REQ-031 start_exec SHALL be ignored in every state except READY.
REQ-032 If start_exec and rx_valid occur in the same cycle in READY, start_exec SHALL win.
REQ-033 ERROR SHALL be sticky, with all inputs ignored; only RESET leaves it.
REQ-034 imem_we SHALL never assert outside LOAD-originated writes.

Reset
REQ-035 On RESET, the block SHALL go to IDLE regardless of state, including mid-load and during RUN.
REQ-036 RESET SHALL clear imem_we, cpu_run, loading, load_done, error, word_count, the byte counter, the word index, and the timeout counter to 0.
REQ-037 RESET SHALL set cpu_rst to 1 for the cycle after RESET is released and 0 thereafter.
REQ-038 The contents of the partially written memory SHALL be don't-care after a reset mid-load.

Verification
REQ-039 Bytes 00 02 53 D3 53 F7 00 53 53 57 SHALL produce writes addr0=0x53D353F7 and addr1=0x00535357, followed by load_done=1 and word_count=2.
REQ-040 Header 00 00 SHALL give READY with no imem_we; start_exec then SHALL give cpu_rst for one cycle, then cpu_run=1; cpu_halt SHALL give cpu_run=0 and load_done=1.
REQ-041 With ADDR_W=4 and header 00 11 (N=17), the block SHALL go to ERROR with error=1, no writes, and later bytes and start_exec ignored.
REQ-042 With TIMEOUT=100, header 00 01 plus 2 bytes and then silence SHALL give error=1 exactly 100 cycles after the last byte; a byte arriving at cycle 100 SHALL instead continue the load.
REQ-043 RESET asserted after 6 of 10 bytes SHALL give IDLE with all outputs 0; a fresh full load SHALL then write from addr0.
REQ-044 In RUN, injected rx_valid and start_exec SHALL produce no imem_we and no cpu_rst.

Source files
------------

// File: rtl/program_loader_if.sv
// Host-side bundle for the program loader: UART byte strobe, run control, CPU status
// and the instruction-memory write port plus loader status outputs.
interface program_loader_if #(
    parameter int ADDR_W = 14
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              start_exec;
    logic              cpu_halt;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst;
    logic              cpu_run;
    logic              loading;
    logic              load_done;
    logic              error;
    logic [15:0]       word_count;

    modport master (
        output rx_valid, rx_data, start_exec, cpu_halt,
        input  imem_we, imem_addr, imem_wdata, cpu_rst, cpu_run,
               loading, load_done, error, word_count
    );

    modport slave (
        input  rx_valid, rx_data, start_exec, cpu_halt,
        output imem_we, imem_addr, imem_wdata, cpu_rst, cpu_run,
               loading, load_done, error, word_count
    );
endinterface

// File: rtl/program_loader.sv
// Loads a 16-bit word count then big-endian 32-bit words from a UART byte stream into imem.
// One-cycle write latency after the 4th byte; no backpressure, bytes are accepted every cycle.
module program_loader #(
    parameter int ADDR_W  = 14,
    parameter int TIMEOUT = 1000000
) (
    input  logic             CLK,
    input  logic             RESET,
    program_loader_if.slave  bus
);
    localparam int                TO_W      = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [16:0]       MAX_WORDS = 17'(1) << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LOAD,
        S_READY,
        S_RUN,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       n_q, n_d;
    logic [23:0]       shift_q, shift_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              cpu_run_q, cpu_run_d;
    logic              loading_q, loading_d;
    logic              load_done_q, load_done_d;
    logic              error_q, error_d;

    logic              in_load_phase;
    logic              timed_out;
    logic              last_word;
    logic [15:0]       hdr_n;
    logic [16:0]       idx_next;

    assign in_load_phase = (state_q == S_HDR) || (state_q == S_LOAD);
    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign timed_out     = in_load_phase && !bus.rx_valid && (to_cnt_q == TO_LAST);
    assign hdr_n         = {n_q[15:8], bus.rx_data};
    assign idx_next      = 17'(word_idx_q) + 17'd1;
    assign last_word     = (idx_next == {1'b0, n_q});

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        shift_d      = shift_q;
        byte_cnt_d   = byte_cnt_q;
        word_idx_d   = word_idx_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        cpu_rst_d    = 1'b0;
        to_cnt_d     = (bus.rx_valid || !in_load_phase) ? '0 : to_cnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (bus.rx_valid) begin
                    n_d        = {bus.rx_data, 8'h00};
                    byte_cnt_d = '0;
                    word_idx_d = '0;
                    state_d    = S_HDR;
                end
            end
            S_HDR: begin
                if (bus.rx_valid) begin
                    n_d = hdr_n;
                    if (hdr_n == 16'd0) begin
                        state_d = S_READY;
                    end else if ({1'b0, hdr_n} > MAX_WORDS) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else if (timed_out) begin
                    state_d = S_ERROR;
                end
            end
            S_LOAD: begin
                if (bus.rx_valid) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    shift_d    = {shift_q[15:0], bus.rx_data};
                    if (byte_cnt_q == 2'd3) begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = word_idx_q;
                        imem_wdata_d = {shift_q, bus.rx_data};
                        if (last_word) begin
                            state_d = S_READY;
                        end else begin
                            word_idx_d = idx_next[ADDR_W-1:0];
                        end
                    end
                end else if (timed_out) begin
                    state_d = S_ERROR;
                end
            end
            S_READY: begin
                if (bus.start_exec) begin
                    cpu_rst_d = 1'b1;
                    state_d   = S_RUN;
                end else if (bus.rx_valid) begin
                    n_d        = {bus.rx_data, 8'h00};
                    byte_cnt_d = '0;
                    word_idx_d = '0;
                    state_d    = S_HDR;
                end
            end
            S_RUN: begin
                if (bus.cpu_halt) begin
                    state_d = S_READY;
                end
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        loading_d   = (state_d == S_HDR) || (state_d == S_LOAD);
        load_done_d = (state_d == S_READY);
        error_d     = (state_d == S_ERROR);
        // The cycle entering RUN carries cpu_rst; execution is enabled from the next one.
        cpu_run_d   = (state_q == S_RUN) && (state_d == S_RUN);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            n_q          <= '0;
            shift_q      <= '0;
            byte_cnt_q   <= '0;
            word_idx_q   <= '0;
            to_cnt_q     <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_rst_q    <= 1'b1;
            cpu_run_q    <= 1'b0;
            loading_q    <= 1'b0;
            load_done_q  <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            shift_q      <= shift_d;
            byte_cnt_q   <= byte_cnt_d;
            word_idx_q   <= word_idx_d;
            to_cnt_q     <= to_cnt_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_rst_q    <= cpu_rst_d;
            cpu_run_q    <= cpu_run_d;
            loading_q    <= loading_d;
            load_done_q  <= load_done_d;
            error_q      <= error_d;
        end
    end

    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.cpu_rst    = cpu_rst_q;
    assign bus.cpu_run    = cpu_run_q;
    assign bus.loading    = loading_q;
    assign bus.load_done  = load_done_q;
    assign bus.error      = error_q;
    assign bus.word_count = n_q;
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader (ADDR_W=4, TIMEOUT=100): per-cycle comparison against a
// byte-count based behavioural model, plus literal expectations for the documented scenarios.
module tb_program_loader;
    localparam int AW = 4;
    localparam int TO = 100;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    program_loader_if #(.ADDR_W(AW)) bus ();

    program_loader #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model: tracks bytes received in the current load and derives writes from them.
    bit          m_err, m_loading, m_ready, m_we, m_rst;
    int          m_phase;  // 0 = not executing, 1 = start accepted, 2 = executing
    int          m_nb, m_idle, m_addr;
    logic [15:0] m_n;
    logic [31:0] m_word, m_wdata;

    always @(posedge CLK) begin
        m_we  = 1'b0;
        m_rst = 1'b0;
        if (RESET) begin
            m_err = 0; m_loading = 0; m_ready = 0; m_phase = 0;
            m_nb = 0; m_idle = 0; m_n = 0; m_rst = 1'b1;
        end else if (m_err) begin
            m_err = 1'b1;
        end else if (m_phase == 1) begin
            m_phase = bus.cpu_halt ? 0 : 2;
        end else if (m_phase == 2) begin
            if (bus.cpu_halt) m_phase = 0;
        end else if (m_ready && bus.start_exec) begin
            m_phase = 1;
            m_rst   = 1'b1;
        end else if (m_loading) begin
            if (bus.rx_valid) begin
                m_idle = 0;
                m_nb++;
                if (m_nb == 2) begin
                    m_n = m_n | 16'(bus.rx_data);
                    if (m_n == 0) begin
                        m_loading = 0; m_ready = 1;
                    end else if (int'(m_n) > (1 << AW)) begin
                        m_loading = 0; m_err = 1;
                    end
                end else begin
                    m_word = (m_word << 8) | 32'(bus.rx_data);
                    if ((m_nb - 2) % 4 == 0) begin
                        m_we    = 1'b1;
                        m_addr  = (m_nb - 2) / 4 - 1;
                        m_wdata = m_word;
                        if (m_addr == int'(m_n) - 1) begin
                            m_loading = 0; m_ready = 1;
                        end
                    end
                end
            end else begin
                m_idle++;
                if (m_idle == TO) begin
                    m_loading = 0; m_err = 1;
                end
            end
        end else if (bus.rx_valid) begin
            m_loading = 1; m_ready = 0; m_nb = 1; m_idle = 0; m_word = 0;
            m_n = {bus.rx_data, 8'h00};
        end
    end

    logic [47:0] wr_log[$];

    always @(negedge CLK) begin
        if (chk_en) begin
            check("c_loading",   48'(bus.loading),    48'(m_loading));
            check("c_load_done", 48'(bus.load_done),  48'(m_ready && m_phase == 0 && !m_loading));
            check("c_error",     48'(bus.error),      48'(m_err));
            check("c_word_count",48'(bus.word_count), 48'(m_n));
            check("c_cpu_run",   48'(bus.cpu_run),    48'(m_phase == 2));
            check("c_cpu_rst",   48'(bus.cpu_rst),    48'(m_rst));
            check("c_imem_we",   48'(bus.imem_we),    48'(m_we));
            if (m_we) begin
                check("c_imem_addr",  48'(bus.imem_addr),  48'(m_addr));
                check("c_imem_wdata", 48'(bus.imem_wdata), 48'(m_wdata));
            end
            if (bus.imem_we === 1'b1) wr_log.push_back({16'(bus.imem_addr), bus.imem_wdata});
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        tick();
        bus.rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    function automatic logic [47:0] log_at(input int i);
        if (i < wr_log.size()) return wr_log[i];
        return 'x;
    endfunction

    logic [7:0] prog_a [10] = '{8'h00, 8'h02, 8'h53, 8'hD3, 8'h53, 8'hF7, 8'h00, 8'h53, 8'h53, 8'h57};
    logic [7:0] prog_b [10] = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h5A, 8'hC3, 8'h3C};
    int base;

    initial begin
        RESET = 1'b1;
        bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
        bus.start_exec = 1'b0; bus.cpu_halt = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        RESET = 1'b0;
        check("rst_cpu_rst_high", 48'(bus.cpu_rst), 48'd1);
        check("rst_word_count",   48'(bus.word_count), 48'd0);
        check("rst_loading",      48'(bus.loading), 48'd0);
        tick();
        check("rst_cpu_rst_low",  48'(bus.cpu_rst), 48'd0);

        // Two-word program with irregular byte spacing.
        base = wr_log.size();
        for (int i = 0; i < 10; i++) send_byte(prog_a[i], i % 3);
        check("load_we_pulse",    48'(bus.imem_we | bus.load_done), 48'd1);
        tick();
        check("load_we_one_cycle",48'(bus.imem_we), 48'd0);
        check("load_n_writes",    48'(wr_log.size() - base), 48'd2);
        check("load_word0",       log_at(base),     {16'd0, 32'h53D353F7});
        check("load_word1",       log_at(base + 1), {16'd1, 32'h00535357});
        check("load_done",        48'(bus.load_done), 48'd1);
        check("load_word_count",  48'(bus.word_count), 48'd2);

        // Empty program, execute, inject traffic while running, halt, re-run.
        base = wr_log.size();
        send_byte(8'h00, 1);
        send_byte(8'h00, 1);
        check("empty_ready",      48'(bus.load_done), 48'd1);
        check("empty_no_writes",  48'(wr_log.size() - base), 48'd0);
        bus.start_exec = 1'b1; tick(); bus.start_exec = 1'b0;
        check("exec_cpu_rst",     48'(bus.cpu_rst), 48'd1);
        check("exec_run_low",     48'(bus.cpu_run), 48'd0);
        tick();
        check("exec_cpu_rst_off", 48'(bus.cpu_rst), 48'd0);
        check("exec_run_high",    48'(bus.cpu_run), 48'd1);
        bus.start_exec = 1'b1; bus.rx_valid = 1'b1; bus.rx_data = 8'h77;
        tick();
        bus.start_exec = 1'b0; bus.rx_valid = 1'b0;
        check("run_ignore_rst",   48'(bus.cpu_rst), 48'd0);
        for (int i = 0; i < 5; i++) send_byte(8'(8'h10 + i), 0);
        check("run_no_writes",    48'(wr_log.size() - base), 48'd0);
        check("run_still_run",    48'(bus.cpu_run), 48'd1);
        bus.cpu_halt = 1'b1; tick(); bus.cpu_halt = 1'b0;
        check("halt_run_low",     48'(bus.cpu_run), 48'd0);
        check("halt_load_done",   48'(bus.load_done), 48'd1);
        bus.start_exec = 1'b1; bus.rx_valid = 1'b1; bus.rx_data = 8'h00;
        tick();
        bus.start_exec = 1'b0; bus.rx_valid = 1'b0;
        check("start_beats_rx_rst", 48'(bus.cpu_rst), 48'd1);
        check("start_beats_rx_ld",  48'(bus.loading), 48'd0);
        repeat (3) tick();
        bus.cpu_halt = 1'b1; tick(); bus.cpu_halt = 1'b0;

        // Oversized header from READY is a sticky error.
        base = wr_log.size();
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        check("err_flag",         48'(bus.error), 48'd1);
        check("err_word_count",   48'(bus.word_count), 48'h11);
        for (int i = 0; i < 6; i++) send_byte(8'(8'hE0 + i), 0);
        bus.start_exec = 1'b1; tick(); bus.start_exec = 1'b0;
        check("err_ignore_start", 48'(bus.cpu_rst), 48'd0);
        check("err_sticky",       48'(bus.error), 48'd1);
        check("err_no_writes",    48'(wr_log.size() - base), 48'd0);

        // N equal to the memory depth is legal.
        do_reset(); tick();
        send_byte(8'h00, 0);
        send_byte(8'h10, 0);
        check("max_n_loading",    48'(bus.loading), 48'd1);
        check("max_n_no_err",     48'(bus.error), 48'd0);

        // Inter-byte timeout fires exactly TO cycles after the last byte.
        do_reset(); tick();
        send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'hAA, 0); send_byte(8'hBB, 0);
        repeat (TO - 1) tick();
        check("to_not_yet",       48'(bus.error), 48'd0);
        tick();
        check("to_fired",         48'(bus.error), 48'd1);

        // A byte on the expiry cycle keeps the load alive.
        do_reset(); tick();
        base = wr_log.size();
        send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'hAA, 0); send_byte(8'hBB, 0);
        repeat (TO - 1) tick();
        send_byte(8'hCC, 0);
        check("to_byte_wins_err", 48'(bus.error), 48'd0);
        check("to_byte_wins_ld",  48'(bus.loading), 48'd1);
        send_byte(8'hDD, 1);
        check("to_byte_word",     log_at(base), {16'd0, 32'hAABBCCDD});
        check("to_byte_done",     48'(bus.load_done), 48'd1);

        // Reset mid-load, then a fresh load restarts at address 0.
        do_reset(); tick();
        for (int i = 0; i < 6; i++) send_byte(prog_a[i], 0);
        RESET = 1'b1; tick(); RESET = 1'b0;
        check("mid_rst_cpu_rst",  48'(bus.cpu_rst), 48'd1);
        tick();
        check("mid_rst_outputs",
              {bus.imem_we, bus.cpu_rst, bus.cpu_run, bus.loading, bus.load_done, bus.error,
               bus.word_count, 12'(bus.imem_addr)}, 48'd0);
        check("mid_rst_wdata",    48'(bus.imem_wdata), 48'd0);
        base = wr_log.size();
        for (int i = 0; i < 10; i++) send_byte(prog_b[i], 0);
        tick();
        check("fresh_word0",      log_at(base),     {16'd0, 32'h11223344});
        check("fresh_word1",      log_at(base + 1), {16'd1, 32'hA55AC33C});
        check("fresh_done",       48'(bus.load_done), 48'd1);

        repeat (2) tick();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
